// File: rtl/rowstat_upd_pkg.sv
// rowstat_upd_pkg: shared widths, constants, exp table and FSM encoding for the row-statistics stage
package rowstat_upd_pkg;
  localparam int D_W = 8;
  localparam int TIL = 16;
  localparam int CW = $clog2(TIL);
  localparam logic [D_W-1:0] EXP_ONE = {1'b1, {(D_W-1){1'b0}}};
  localparam logic signed [D_W-1:0] M_INIT = {1'b1, {(D_W-1){1'b0}}};
  localparam logic [2*D_W-1:0] L_SAT = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIL-1);
  // 2^(-f/16) in Q1.7; exp argument uses 16 steps per halving
  localparam logic [D_W-1:0] EXP_FRAC [16] = '{
    8'd128, 8'd123, 8'd117, 8'd112, 8'd108, 8'd103, 8'd99, 8'd95,
    8'd91, 8'd87, 8'd83, 8'd79, 8'd76, 8'd73, 8'd70, 8'd67
  };
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/rowstat_upd_if.sv
// rowstat_upd_if: score-column input, release handshake and per-row statistics outputs
interface rowstat_upd_if;
  import rowstat_upd_pkg::*;
  logic I_ROW_CLR;
  logic I_COL_VLD;
  logic I_ACK;
  logic O_RDY;
  logic O_VLD;
  logic [0:TIL-1][D_W-1:0] I_S_COL;
  logic [0:TIL-1][D_W-1:0] O_MI_OLD;
  logic [0:TIL-1][D_W-1:0] O_MI_NEW;
  logic [0:TIL-1][2*D_W-1:0] O_LI_OLD;
  logic [0:TIL-1][2*D_W-1:0] O_LI_NEW;
  modport master (
    output I_ROW_CLR, I_COL_VLD, I_S_COL, I_ACK,
    input O_RDY, O_VLD, O_MI_OLD, O_MI_NEW, O_LI_OLD, O_LI_NEW
  );
  modport slave (
    input I_ROW_CLR, I_COL_VLD, I_S_COL, I_ACK,
    output O_RDY, O_VLD, O_MI_OLD, O_MI_NEW, O_LI_OLD, O_LI_NEW
  );
endinterface

// File: rtl/rowstat_upd_lane.sv
// rowstat_lane: one row's combinational max / exp-sum update; Exp_x: Q1.7 exp of a non-positive score difference
module Exp_x
  import rowstat_upd_pkg::*;
(
  input  logic signed [D_W-1:0] i_x,
  output logic [D_W-1:0]        o_y
);
  logic [D_W:0] w_n;
  assign w_n = -{i_x[D_W-1], i_x};
  assign o_y = i_x[D_W-1] ? EXP_FRAC[w_n[3:0]] >> w_n[D_W:4] : EXP_ONE;
endmodule

module rowstat_lane
  import rowstat_upd_pkg::*;
(
  input  logic signed [D_W-1:0] i_m,
  input  logic signed [D_W-1:0] i_s,
  input  logic [2*D_W-1:0]      i_l,
  output logic signed [D_W-1:0] o_m,
  output logic [2*D_W-1:0]      o_l
);
  logic [D_W:0] w_d1, w_d2;
  logic signed [D_W-1:0] w_x1, w_x2;
  logic [D_W-1:0] w_e1, w_e2;
  logic [3*D_W-1:0] w_prod;
  logic [2*D_W+1:0] w_sum;
  assign o_m = (i_s > i_m) ? i_s : i_m;
  assign w_d1 = {i_m[D_W-1], i_m} - {o_m[D_W-1], o_m};
  assign w_d2 = {i_s[D_W-1], i_s} - {o_m[D_W-1], o_m};
  // differences are never positive, so overflow can only be downward
  assign w_x1 = (w_d1[D_W] != w_d1[D_W-1]) ? M_INIT : w_d1[D_W-1:0];
  assign w_x2 = (w_d2[D_W] != w_d2[D_W-1]) ? M_INIT : w_d2[D_W-1:0];
  Exp_x u_exp1 (.i_x(w_x1), .o_y(w_e1));
  Exp_x u_exp2 (.i_x(w_x2), .o_y(w_e2));
  assign w_prod = (3*D_W)'(i_l) * (3*D_W)'(w_e1);
  assign w_sum = (2*D_W+2)'(w_prod[3*D_W-1:D_W-1]) + (2*D_W+2)'(w_e2);
  assign o_l = (|w_sum[2*D_W+1:2*D_W]) ? L_SAT : w_sum[2*D_W-1:0];
endmodule

// File: rtl/rowstat_upd.sv
// rowstat_upd: online-softmax running max / exp-sum per row across score tiles, held until acknowledged
module rowstat_upd
  import rowstat_upd_pkg::*;
(
  input logic I_CLK,
  input logic I_RST,
  rowstat_upd_if.slave bus
);
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [0:TIL-1][D_W-1:0] r_m, r_mo, w_m_nxt;
  logic [0:TIL-1][2*D_W-1:0] r_l, r_lo, w_l_nxt;
  logic w_acc;
  assign w_acc = bus.I_COL_VLD & (r_state != HOLD) & ~bus.I_ROW_CLR;
  assign bus.O_RDY = r_state != HOLD;
  assign bus.O_VLD = r_state == HOLD;
  assign bus.O_MI_OLD = r_mo;
  assign bus.O_LI_OLD = r_lo;
  assign bus.O_MI_NEW = r_m;
  assign bus.O_LI_NEW = r_l;
  for (genvar r = 0; r < TIL; r++) begin : g_lane
    rowstat_lane u_lane (
      .i_m(r_m[r]),
      .i_s(bus.I_S_COL[r]),
      .i_l(r_l[r]),
      .o_m(w_m_nxt[r]),
      .o_l(w_l_nxt[r])
    );
  end
  always_comb begin
    w_state_nxt = r_state;
    if (bus.I_ROW_CLR) w_state_nxt = IDLE;
    else if (r_state == HOLD) w_state_nxt = bus.I_ACK ? IDLE : HOLD;
    else if (w_acc) w_state_nxt = (r_cnt == CNT_LAST) ? HOLD : ACCUM;
  end
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_m <= {TIL{M_INIT}};
      r_l <= '0;
      r_mo <= {TIL{M_INIT}};
      r_lo <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= bus.I_ROW_CLR ? '0 : !w_acc ? r_cnt : (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
      if (bus.I_ROW_CLR) begin
        r_m <= {TIL{M_INIT}};
        r_l <= '0;
      end else if (w_acc) begin
        r_m <= w_m_nxt;
        r_l <= w_l_nxt;
      end
      if (w_acc && r_cnt == '0) begin
        r_mo <= r_m;
        r_lo <= r_l;
      end
    end
  end
endmodule
